// File: rtl/loader_pkg.sv
// Shared types and constants for the program-RAM loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_FILL
  } state_e;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         PROG_DEPTH  = 16;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader into program RAM; writes land one cycle after the accepting edge.
// in_ready drops only while zero-filling the tail; CPU is held in clear until a checksum-good image is in.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] HDR = HDR_DEFAULT,
  parameter int         AW  = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wdata,
  output logic          cpu_clr,
  output logic          busy,
  output logic          err
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] LAST    = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

  state_e        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   addr_q, addr_d;
  logic [7:0]    sum_q, sum_d;
  logic          run_q, run_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic acc;
  logic cnt_ok;

  assign in_ready = (state_q != ST_FILL);
  assign acc      = in_valid && in_ready;
  assign cnt_ok   = (in_data != 8'h00) && ({1'b0, in_data} <= 9'(DEPTH));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    run_d   = run_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (acc && in_data == HDR) begin
          run_d   = 1'b0;
          err_d   = 1'b0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (acc) begin
          if (cnt_ok) begin
            n_d     = in_data[AW:0];
            addr_d  = '0;
            sum_d   = '0;
            state_d = ST_DATA;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (acc) begin
          we_d    = 1'b1;
          waddr_d = addr_q[AW-1:0];
          wdata_d = in_data;
          addr_d  = addr_q + ONE;
          sum_d   = sum_q + in_data;
          if (addr_q + ONE == n_q) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (acc) begin
          if (sum_q + in_data == 8'h00) begin
            if (n_q == DEPTH_W) begin
              run_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FILL: begin
        // addr_q already points at N, the first unwritten word
        we_d    = 1'b1;
        waddr_d = addr_q[AW-1:0];
        wdata_d = 8'h00;
        addr_d  = addr_q + ONE;
        if (addr_q == LAST) begin
          run_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      run_q   <= run_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ram_we    = we_q;
  assign ram_addr  = waddr_q;
  assign ram_wdata = wdata_q;
  assign cpu_clr   = ~run_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: expected RAM writes are queued as frames are driven.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_clr;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [11:0] exp_q[$];

  prog_loader dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_clr   (cpu_clr),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h", ram_addr, ram_wdata);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          failures++;
          $display("FAIL write got addr=%0h data=%0h want addr=%0h data=%0h",
                   ram_addr, ram_wdata, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%0h in_ready=%b want 1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Sends HDR, n, data, checksum; queues the data writes and, for a good
  // short image, the zero-fill writes. Returns #1 after the checksum edge.
  task automatic send_image(input int n, input logic [7:0] d[16], input int gap,
                            input bit use_c, input logic [7:0] c_val);
    logic [7:0] sum;
    logic [7:0] c;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      sum = sum + d[i];
      exp_q.push_back({4'(i), d[i]});
    end
    c = use_c ? c_val : (8'h00 - sum);
    if (8'(sum + c) == 8'h00)
      for (int i = n; i < 16; i++) exp_q.push_back({4'(i), 8'h00});
    send_byte(8'hA5);
    idle(gap);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      idle(gap);
      send_byte(d[i]);
    end
    idle(gap);
    send_byte(c);
  endtask

  task automatic drain(input string name);
    idle(20);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending_writes=%0d want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    clr = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    idle(3);
    clr = 1'b0;
    checks++;
    if ({cpu_clr, in_ready, err, ram_we, busy, ram_addr, ram_wdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00}) begin
      failures++;
      $display("FAIL reset cpu_clr=%b in_ready=%b err=%b we=%b busy=%b addr=%0h wd=%0h want 1 1 0 0 0 0 0",
               cpu_clr, in_ready, err, ram_we, busy, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_full_image;
    logic [7:0] d[16];
    int w0;
    for (int i = 0; i < 16; i++) d[i] = 8'(i);
    w0 = wr_cnt;
    send_image(16, d, 0, 1'b1, 8'h88);
    checks++;
    if (cpu_clr !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_release cpu_clr=%b err=%b busy=%b want 0 0 0", cpu_clr, err, busy);
    end
    drain("full_drain");
    checks++;
    if (wr_cnt - w0 != 16) begin
      failures++;
      $display("FAIL full_wr_count got=%0d want 16", wr_cnt - w0);
    end
  endtask

  task automatic test_hdr_reasserts;
    send_byte(8'hA5);
    checks++;
    if (cpu_clr !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL hdr_reclear cpu_clr=%b busy=%b want 1 1", cpu_clr, busy);
    end
    send_byte(8'h00);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_count0 err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  task automatic test_short_image;
    logic [7:0] d[16];
    int low;
    int w0;
    d = '{default: 8'h00};
    d[0] = 8'h1E; d[1] = 8'h2F; d[2] = 8'hE0;
    w0 = wr_cnt;
    send_image(3, d, 0, 1'b1, 8'hD3);
    checks++;
    if (cpu_clr !== 1'b1) begin
      failures++;
      $display("FAIL short_hold_during_fill cpu_clr=%b want 1", cpu_clr);
    end
    low = 0;
    while (in_ready === 1'b0 && low < 50) begin
      low++;
      @(posedge clk); #1;
    end
    checks++;
    if (low != 13) begin
      failures++;
      $display("FAIL short_ready_low cycles=%0d want 13", low);
    end
    checks++;
    if (cpu_clr !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL short_release cpu_clr=%b err=%b want 0 0", cpu_clr, err);
    end
    drain("short_drain");
    checks++;
    if (wr_cnt - w0 != 16) begin
      failures++;
      $display("FAIL short_wr_count got=%0d want 16", wr_cnt - w0);
    end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] d[16];
    int w0;
    d = '{default: 8'h00};
    d[0] = 8'h55;
    w0 = wr_cnt;
    send_image(1, d, 0, 1'b1, 8'h00);
    checks++;
    if (err !== 1'b1 || cpu_clr !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL badsum err=%b cpu_clr=%b in_ready=%b busy=%b want 1 1 1 0", err, cpu_clr, in_ready, busy);
    end
    drain("badsum_drain");
    checks++;
    if (wr_cnt - w0 != 1) begin
      failures++;
      $display("FAIL badsum_wr_count got=%0d want 1", wr_cnt - w0);
    end
  endtask

  task automatic test_bad_count;
    logic [7:0] d[16];
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA5);
    send_byte(8'h11);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_clr !== 1'b1) begin
      failures++;
      $display("FAIL bad_count17 err=%b busy=%b cpu_clr=%b want 1 0 1", err, busy, cpu_clr);
    end
    idle(3);
    checks++;
    if (wr_cnt != w0) begin
      failures++;
      $display("FAIL bad_count_writes got=%0d want 0", wr_cnt - w0);
    end
    d = '{default: 8'h00};
    d[0] = 8'h12; d[1] = 8'hA5;
    send_image(2, d, 0, 1'b0, 8'h00);
    idle(15);
    checks++;
    if (err !== 1'b0 || cpu_clr !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared err=%b cpu_clr=%b want 0 0", err, cpu_clr);
    end
    drain("recover_drain");
  endtask

  task automatic test_garbage_and_gaps;
    logic [7:0] d[16];
    send_byte(8'h00);
    send_byte(8'hFF);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL garbage_busy busy=%b want 0", busy);
    end
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom_range(0, 255));
    send_image(5, d, 2, 1'b0, 8'h00);
    idle(15);
    checks++;
    if (cpu_clr !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL gaps_release cpu_clr=%b err=%b want 0 0", cpu_clr, err);
    end
    drain("gaps_drain");
  endtask

  task automatic test_clr_mid_frame;
    int w0;
    send_byte(8'hA5);
    send_byte(8'h04);
    exp_q.push_back({4'h0, 8'h11});
    exp_q.push_back({4'h1, 8'h22});
    send_byte(8'h11);
    send_byte(8'h22);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    w0 = wr_cnt;
    checks++;
    if (busy !== 1'b0 || cpu_clr !== 1'b1 || err !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 4'h0 || ram_wdata !== 8'h00) begin
      failures++;
      $display("FAIL clr_mid busy=%b cpu_clr=%b err=%b we=%b addr=%0h wd=%0h want 0 1 0 0 0 0",
               busy, cpu_clr, err, ram_we, ram_addr, ram_wdata);
    end
    send_byte(8'h33);
    send_byte(8'h44);
    idle(3);
    checks++;
    if (wr_cnt != w0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clr_no_writes writes=%0d busy=%b want 0 0", wr_cnt - w0, busy);
    end
    drain("clr_drain");
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_hdr_reasserts();
    test_short_image();
    test_bad_checksum();
    test_bad_count();
    test_garbage_and_gaps();
    test_clr_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
